// File: rtl/im_sram_arbiter.sv
// im_sram_arbiter: shares the single item-memory SRAM port between the host
// loader (writes) and the encoder (reads). All SRAM pins are registered; read
// data returns through a 4-entry in-order response FIFO. Read requests are
// admitted only while the FIFO and the two-stage read pipeline have room.
// Tracks load completion and out-of-range host writes with sticky flags.
//
// Build option: define IM_SRAM_RR_ARB_EN for round-robin arbitration between
// the two requesters. By default, writes have fixed priority.
module im_sram_arbiter #(
  parameter int FOLD_WIDTH      = 500,
  parameter int SRAM_ADDR_WIDTH = 10,
  parameter int NUM_ENTRIES     = 856
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  input  logic [FOLD_WIDTH-1:0]      wr_data,
  input  logic                       rd_req_valid,
  output logic                       rd_req_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  output logic                       rd_resp_valid,
  input  logic                       rd_resp_ready,
  output logic [FOLD_WIDTH-1:0]      rd_resp_data,
  output logic                       sram_cen,
  output logic                       sram_wen,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [FOLD_WIDTH-1:0]      sram_din,
  input  logic [FOLD_WIDTH-1:0]      sram_dout,
  output logic                       load_done,
  output logic                       wr_err
);

  // One extra bit so the counter can hold NUM_ENTRIES == 2^SRAM_ADDR_WIDTH.
  localparam int CW = SRAM_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] NUM_ENT = CW'(NUM_ENTRIES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic                  wr_hs;
  logic                  rd_hs;
  logic                  wr_in_range;
  logic                  credit_ok;
  logic                  rd_pipe1;   // read access on the SRAM pins this cycle
  logic                  rd_pipe2;   // sram_dout carries read data this cycle
  logic [2:0]            occ;
  logic [2:0]            fifo_cnt;
  logic [1:0]            fifo_wptr;
  logic [1:0]            fifo_rptr;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [FOLD_WIDTH-1:0] fifo_mem [4];
  logic [CW-1:0]         load_cnt;

  assign wr_hs       = wr_valid && wr_ready;
  assign rd_hs       = rd_req_valid && rd_req_ready;
  assign wr_in_range = ({1'b0, wr_addr} < NUM_ENT);

  // Every admitted read owns a FIFO slot until it is popped; a pop in this
  // same cycle does not free its slot until the next cycle.
  assign occ       = fifo_cnt + {2'b00, rd_pipe1} + {2'b00, rd_pipe2};
  assign credit_ok = (occ < 3'd4);

`ifdef IM_SRAM_RR_ARB_EN
  logic last_wr;
  logic rd_eligible;

  assign rd_eligible = rd_req_valid && credit_ok;

  // Round-robin grant: under contention, serve whichever side did not win last.
  always_comb begin
    wr_ready     = 1'b0;
    rd_req_ready = 1'b0;
    if (rst) begin
      if (rd_eligible && (!wr_valid || last_wr)) rd_req_ready = 1'b1;
      else                                       wr_ready     = wr_valid;
    end
  end

  // Last-grant memory; starts as "write" so a read wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_wr <= 1'b1;
    else if (wr_hs) last_wr <= 1'b1;
    else if (rd_hs) last_wr <= 1'b0;
  end
`else
  assign wr_ready     = rst && wr_valid;
  assign rd_req_ready = rst && rd_req_valid && !wr_valid && credit_ok;
`endif

  // Registered SRAM pins; address and data hold when the macro is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_addr <= '0;
      sram_din  <= '0;
    end else if (wr_hs && wr_in_range) begin
      sram_cen  <= 1'b0;
      sram_wen  <= 1'b0;
      sram_addr <= wr_addr;
      sram_din  <= wr_data;
    end else if (rd_hs) begin
      sram_cen  <= 1'b0;
      sram_wen  <= 1'b1;
      sram_addr <= rd_addr;
    end else begin
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
    end
  end

  // Read pipeline: access cycle, then the data-return cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pipe1 <= 1'b0;
      rd_pipe2 <= 1'b0;
    end else begin
      rd_pipe1 <= rd_hs;
      rd_pipe2 <= rd_pipe1;
    end
  end

  assign fifo_push     = rd_pipe2;
  assign rd_resp_valid = (fifo_cnt != 3'd0);
  assign fifo_pop      = rd_resp_valid && rd_resp_ready;
  assign rd_resp_data  = rd_resp_valid ? fifo_mem[fifo_rptr] : '0;

  // Response FIFO storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wptr] <= sram_dout;
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_wptr <= '0;
      fifo_rptr <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (fifo_push) fifo_wptr <= fifo_wptr + 2'd1;
      if (fifo_pop)  fifo_rptr <= fifo_rptr + 2'd1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Load progress and sticky status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt  <= '0;
      load_done <= 1'b0;
      wr_err    <= 1'b0;
    end else if (wr_hs) begin
      if (wr_in_range) begin
        if (load_cnt != NUM_ENT) load_cnt <= load_cnt + CNT_ONE;
        if (load_cnt == NUM_ENT - CNT_ONE) load_done <= 1'b1;
      end else begin
        wr_err <= 1'b1;
      end
    end
  end

  // The credit check makes a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst)
    !(fifo_push && !fifo_pop && (fifo_cnt == 3'd4)));

endmodule

// File: tb/tb_im_sram_arbiter.sv
// Self-checking bench for im_sram_arbiter: SRAM behavioural model, shadow
// memory of expected contents, and an outstanding-read credit model.
module tb_im_sram_arbiter;

  localparam int FW = 500;
  localparam int AW = 10;
  localparam int NE = 856;

  logic          clk;
  logic          rst;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [FW-1:0] wr_data;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_resp_valid, rd_resp_ready;
  logic [FW-1:0] rd_resp_data;
  logic          sram_cen, sram_wen;
  logic [AW-1:0] sram_addr;
  logic [FW-1:0] sram_din, sram_dout;
  logic          load_done, wr_err;

  im_sram_arbiter #(.FOLD_WIDTH(FW), .SRAM_ADDR_WIDTH(AW), .NUM_ENTRIES(NE)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready), .rd_resp_data(rd_resp_data),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .load_done(load_done), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: synchronous write, read data one cycle after access.
  logic [FW-1:0] sram_mem [1024];
  always @(posedge clk) begin
    if (!sram_cen && !sram_wen) sram_mem[sram_addr] <= sram_din;
    if (!sram_cen && sram_wen)  sram_dout <= sram_mem[sram_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  logic [FW-1:0] shadow [1024];
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] got_q[$];
  logic [FW-1:0] exp_at_pop[$];
  int            pop_cyc[$];
  int            n_rd_hs = 0, n_pop = 0, n_wr_access = 0, n_any_access = 0, unexp_pops = 0;
  bit            last_wr_model = 1'b1;
  int            cyc = 0;

  // Per-cycle observations
  int            o_cyc;
  logic          o_wr_ready, o_rd_ready, o_cen, o_wen, o_load_done, o_wr_err, o_resp_valid;
  logic [AW-1:0] o_addr;
  logic [FW-1:0] o_din;
  logic          hs_w, hs_r;
  logic [AW-1:0] hs_waddr, hs_raddr;
  logic [FW-1:0] hs_wdata;

  function automatic logic [FW-1:0] pat(input logic [AW-1:0] a);
    return {50{a}};
  endfunction

  function automatic logic [FW-1:0] rnd_fold();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v[FW-1:0];
  endfunction

  // Samples one cycle at the negedge, updates the reference, then advances.
  task automatic tick();
    @(negedge clk);
    o_cyc        = cyc;
    o_wr_ready   = wr_ready;
    o_rd_ready   = rd_req_ready;
    o_cen        = sram_cen;
    o_wen        = sram_wen;
    o_addr       = sram_addr;
    o_din        = sram_din;
    o_load_done  = load_done;
    o_wr_err     = wr_err;
    o_resp_valid = rd_resp_valid;
    hs_w         = wr_valid && wr_ready;
    hs_r         = rd_req_valid && rd_req_ready;
    hs_waddr     = wr_addr;
    hs_wdata     = wr_data;
    hs_raddr     = rd_addr;
    if (!sram_cen) n_any_access++;
    if (!sram_cen && !sram_wen) n_wr_access++;
    if (rd_resp_valid && rd_resp_ready) begin
      n_pop++;
      got_q.push_back(rd_resp_data);
      pop_cyc.push_back(cyc);
      if (exp_q.size() > 0) exp_at_pop.push_back(exp_q.pop_front());
      else begin
        unexp_pops++;
        exp_at_pop.push_back(~rd_resp_data);
      end
    end
    if (hs_w && int'(wr_addr) < NE) shadow[wr_addr] = wr_data;
    if (hs_r) begin
      n_rd_hs++;
      exp_q.push_back(shadow[rd_addr]);
    end
    if (hs_w) last_wr_model = 1'b1;
    else if (hs_r) last_wr_model = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    exp_q.delete(); got_q.delete(); exp_at_pop.delete(); pop_cyc.delete();
    n_rd_hs = 0; n_pop = 0; unexp_pops = 0; last_wr_model = 1'b1;
  endtask

  task automatic set_idle();
    wr_valid = 0; rd_req_valid = 0; wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  task automatic test_reset();
    rst = 0;
    wr_valid = 1; wr_addr = 10'd5; wr_data = rnd_fold();
    rd_req_valid = 1; rd_addr = 10'd7; rd_resp_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (wr_ready !== 1'b0)      begin miscompares++; $display("FAIL rst_wr_ready got %b want 0", wr_ready); end
    vectors++; if (rd_req_ready !== 1'b0)  begin miscompares++; $display("FAIL rst_rd_req_ready got %b want 0", rd_req_ready); end
    vectors++; if (rd_resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rd_resp_valid got %b want 0", rd_resp_valid); end
    vectors++; if (rd_resp_data !== '0)    begin miscompares++; $display("FAIL rst_rd_resp_data got %h want 0", rd_resp_data); end
    vectors++; if (sram_cen !== 1'b1)      begin miscompares++; $display("FAIL rst_sram_cen got %b want 1", sram_cen); end
    vectors++; if (sram_wen !== 1'b1)      begin miscompares++; $display("FAIL rst_sram_wen got %b want 1", sram_wen); end
    vectors++; if (sram_addr !== '0)       begin miscompares++; $display("FAIL rst_sram_addr got %h want 0", sram_addr); end
    vectors++; if (sram_din !== '0)        begin miscompares++; $display("FAIL rst_sram_din got %h want 0", sram_din); end
    vectors++; if (load_done !== 1'b0)     begin miscompares++; $display("FAIL rst_load_done got %b want 0", load_done); end
    vectors++; if (wr_err !== 1'b0)        begin miscompares++; $display("FAIL rst_wr_err got %b want 0", wr_err); end
    set_idle();
    rst = 1;
    clear_model();
    tick();
  endtask

  task automatic test_load();
    int c_last, c_done, base;
    c_last = -1; c_done = -1; base = n_wr_access;
    rd_req_valid = 0; wr_valid = 1;
    for (int a = 0; a < NE; a++) begin
      wr_addr = AW'(a); wr_data = pat(AW'(a));
      tick();
      vectors++;
      if (o_wr_ready !== 1'b1) begin miscompares++; $display("FAIL load_wr_ready addr %0d got %b want 1", a, o_wr_ready); end
      if (o_load_done && c_done < 0) c_done = o_cyc;
      if (hs_w && a == NE-1) c_last = o_cyc;
    end
    wr_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_load_done && c_done < 0) c_done = o_cyc;
    end
    vectors++; if (c_done != c_last + 1) begin miscompares++; $display("FAIL load_done_cycle got %0d want %0d", c_done, c_last + 1); end
    vectors++; if (n_wr_access - base != NE) begin miscompares++; $display("FAIL load_write_count got %0d want %0d", n_wr_access - base, NE); end
    vectors++; if (o_wr_err !== 1'b0) begin miscompares++; $display("FAIL load_wr_err got %b want 0", o_wr_err); end
  endtask

  task automatic test_out_of_range();
    int base;
    wr_valid = 1; wr_addr = 10'd900; wr_data = rnd_fold();
    tick();
    vectors++; if (o_wr_ready !== 1'b1) begin miscompares++; $display("FAIL oor_wr_ready got %b want 1", o_wr_ready); end
    wr_valid = 0;
    base = n_any_access;
    tick();
    vectors++; if (o_cen !== 1'b1)   begin miscompares++; $display("FAIL oor_sram_cen got %b want 1", o_cen); end
    vectors++; if (o_wr_err !== 1'b1) begin miscompares++; $display("FAIL oor_wr_err got %b want 1", o_wr_err); end
    repeat (3) tick();
    vectors++; if (n_any_access != base) begin miscompares++; $display("FAIL oor_no_access got %0d accesses want 0", n_any_access - base); end
    vectors++; if (o_wr_err !== 1'b1)     begin miscompares++; $display("FAIL oor_wr_err_sticky got %b want 1", o_wr_err); end
    vectors++; if (o_load_done !== 1'b1)  begin miscompares++; $display("FAIL oor_load_done got %b want 1", o_load_done); end
  endtask

  task automatic test_stream();
    int first_hs, first_valid, pop_base, n;
    logic [FW-1:0] g, e;
    first_hs = -1; first_valid = -1; pop_base = n_pop;
    pop_cyc.delete();
    wr_valid = 0; rd_resp_ready = 1; rd_req_valid = 1;
    for (int a = 0; a < 200; a++) begin
      rd_addr = AW'(a);
      tick();
      vectors++;
      if (o_rd_ready !== 1'b1) begin miscompares++; $display("FAIL stream_req_ready addr %0d got %b want 1", a, o_rd_ready); end
      if (hs_r && first_hs < 0) first_hs = o_cyc;
      if (o_resp_valid && first_valid < 0) first_valid = o_cyc;
    end
    rd_req_valid = 0;
    for (int i = 0; i < 20 && (n_pop - pop_base) < 200; i++) begin
      tick();
      if (o_resp_valid && first_valid < 0) first_valid = o_cyc;
    end
    n = n_pop - pop_base;
    vectors++; if (first_valid != first_hs + 3) begin miscompares++; $display("FAIL stream_latency got %0d want %0d", first_valid - first_hs, 3); end
    vectors++; if (n != 200) begin miscompares++; $display("FAIL stream_count got %0d want 200", n); end
    vectors++;
    if (pop_cyc.size() != 200 || pop_cyc[pop_cyc.size()-1] - pop_cyc[0] != 199) begin
      miscompares++; $display("FAIL stream_consecutive got %0d pops want 200 on consecutive cycles", pop_cyc.size());
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_at_pop.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL stream_data got %h want %h", g, e); end
    end
  endtask

  task automatic test_backpressure();
    int n_acc, n_acc2;
    logic [FW-1:0] g, e;
    n_acc = 0; n_acc2 = 0;
    rd_resp_ready = 0; rd_req_valid = 1; wr_valid = 0;
    for (int i = 0; i < 8; i++) begin
      rd_addr = AW'($urandom_range(0, NE-1));
      tick();
      if (hs_r) n_acc++;
    end
    vectors++; if (n_acc != 4) begin miscompares++; $display("FAIL bp_accepted got %0d want 4", n_acc); end
    vectors++; if (o_rd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready got %b want 0", o_rd_ready); end
    rd_resp_ready = 1;
    for (int i = 0; i < 12; i++) begin
      rd_addr = AW'($urandom_range(0, NE-1));
      tick();
      if (hs_r) n_acc2++;
    end
    vectors++; if (n_acc2 < 8) begin miscompares++; $display("FAIL bp_resume got %0d accepts want at least 8", n_acc2); end
    rd_req_valid = 0;
    for (int i = 0; i < 20 && n_pop < n_rd_hs; i++) tick();
    vectors++; if (n_pop != n_rd_hs) begin miscompares++; $display("FAIL bp_drain got %0d responses want %0d", n_pop, n_rd_hs); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_at_pop.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL bp_data got %h want %h", g, e); end
    end
  endtask

  task automatic test_random();
    bit exp_wr, exp_rd, credit, exp_err;
    bit prev_w, prev_r;
    logic [AW-1:0] prev_waddr, prev_raddr;
    logic [FW-1:0] prev_wdata, g, e;
    set_idle();
    tick();
    prev_w = 0; prev_r = 0; prev_waddr = '0; prev_raddr = '0; prev_wdata = '0;
    exp_err = 1'b1;
    for (int i = 0; i < 400; i++) begin
      wr_valid      = ($urandom_range(0, 99) < 30);
      wr_addr       = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(NE, 1023)) : AW'($urandom_range(0, NE-1));
      wr_data       = rnd_fold();
      rd_req_valid  = 1'($urandom_range(0, 1));
      rd_addr       = AW'($urandom_range(0, NE-1));
      rd_resp_ready = ($urandom_range(0, 99) < 60);
      credit = (n_rd_hs - n_pop) < 4;
`ifdef IM_SRAM_RR_ARB_EN
      exp_rd = rd_req_valid && credit && (!wr_valid || last_wr_model);
      exp_wr = wr_valid && !exp_rd;
`else
      exp_wr = wr_valid;
      exp_rd = rd_req_valid && !wr_valid && credit;
`endif
      tick();
      vectors++; if (o_wr_ready !== exp_wr) begin miscompares++; $display("FAIL rnd_wr_ready cyc %0d got %b want %b", o_cyc, o_wr_ready, exp_wr); end
      vectors++; if (o_rd_ready !== exp_rd) begin miscompares++; $display("FAIL rnd_rd_req_ready cyc %0d got %b want %b", o_cyc, o_rd_ready, exp_rd); end
      vectors++;
      if (prev_w) begin
        if (o_cen !== 1'b0 || o_wen !== 1'b0 || o_addr !== prev_waddr || o_din !== prev_wdata) begin
          miscompares++; $display("FAIL rnd_sram_write cyc %0d got cen %b wen %b addr %0d want write addr %0d", o_cyc, o_cen, o_wen, o_addr, prev_waddr);
        end
      end else if (prev_r) begin
        if (o_cen !== 1'b0 || o_wen !== 1'b1 || o_addr !== prev_raddr) begin
          miscompares++; $display("FAIL rnd_sram_read cyc %0d got cen %b wen %b addr %0d want read addr %0d", o_cyc, o_cen, o_wen, o_addr, prev_raddr);
        end
      end else if (o_cen !== 1'b1 || o_wen !== 1'b1) begin
        miscompares++; $display("FAIL rnd_sram_idle cyc %0d got cen %b wen %b want 1 1", o_cyc, o_cen, o_wen);
      end
      vectors++; if (o_wr_err !== exp_err) begin miscompares++; $display("FAIL rnd_wr_err cyc %0d got %b want %b", o_cyc, o_wr_err, exp_err); end
      vectors++; if (o_load_done !== 1'b1) begin miscompares++; $display("FAIL rnd_load_done cyc %0d got %b want 1", o_cyc, o_load_done); end
      prev_w = hs_w && int'(hs_waddr) < NE;
      prev_r = hs_r;
      prev_waddr = hs_waddr; prev_wdata = hs_wdata; prev_raddr = hs_raddr;
      if (hs_w && int'(hs_waddr) >= NE) exp_err = 1'b1;
    end
    set_idle();
    rd_resp_ready = 1;
    for (int i = 0; i < 20 && n_pop < n_rd_hs; i++) tick();
    vectors++; if (n_pop != n_rd_hs) begin miscompares++; $display("FAIL rnd_drain got %0d responses want %0d", n_pop, n_rd_hs); end
    vectors++; if (unexp_pops != 0) begin miscompares++; $display("FAIL rnd_unexpected_resp got %0d want 0", unexp_pops); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_at_pop.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL rnd_data got %h want %h", g, e); end
    end
  endtask

  task automatic test_contention();
    logic [FW-1:0] g, e;
    byte got_g, want_g;
    set_idle();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    clear_model();
    rd_resp_ready = 1; wr_valid = 1; rd_req_valid = 1;
    for (int i = 0; i < 6; i++) begin
      wr_addr = AW'($urandom_range(0, NE-1)); wr_data = rnd_fold();
      rd_addr = AW'($urandom_range(0, NE-1));
      tick();
      got_g = hs_w ? "W" : (hs_r ? "R" : "-");
`ifdef IM_SRAM_RR_ARB_EN
      want_g = (i % 2 == 0) ? "R" : "W";
`else
      want_g = "W";
`endif
      vectors++; if (got_g != want_g) begin miscompares++; $display("FAIL contention_grant %0d got %c want %c", i, got_g, want_g); end
    end
    set_idle();
    for (int i = 0; i < 20 && n_pop < n_rd_hs; i++) tick();
    vectors++; if (n_pop != n_rd_hs) begin miscompares++; $display("FAIL contention_drain got %0d responses want %0d", n_pop, n_rd_hs); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_at_pop.pop_front();
      vectors++; if (g !== e) begin miscompares++; $display("FAIL contention_data got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid_stream();
    int stale;
    set_idle();
    tick();
    rd_resp_ready = 0; rd_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      rd_addr = AW'($urandom_range(0, NE-1));
      tick();
      vectors++; if (o_rd_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_req_ready %0d got %b want 1", i, o_rd_ready); end
    end
    rd_req_valid = 0;
    vectors++; if (rd_resp_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_valid got %b want 1", rd_resp_valid); end
    vectors++; if (sram_cen !== 1'b0)      begin miscompares++; $display("FAIL midrst_pre_cen got %b want 0", sram_cen); end
    rst = 0;
    #1;
    vectors++; if (rd_resp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_resp_valid got %b want 0", rd_resp_valid); end
    vectors++; if (sram_cen !== 1'b1)      begin miscompares++; $display("FAIL midrst_sram_cen got %b want 1", sram_cen); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    clear_model();
    rd_resp_ready = 1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_resp_valid) stale++;
    end
    vectors++; if (stale != 0) begin miscompares++; $display("FAIL midrst_stale_resp got %0d want 0", stale); end
    vectors++; if (o_load_done !== 1'b0) begin miscompares++; $display("FAIL midrst_load_done got %b want 0", o_load_done); end
  endtask

  initial begin
    rst = 0;
    rd_resp_ready = 0;
    set_idle();
    test_reset();
    test_load();
    test_out_of_range();
    test_stream();
    test_backpressure();
    test_random();
    test_contention();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/im_sram_arbiter.md
# im_sram_arbiter

Single-port arbiter and sequencer for the item-memory (IM) SRAM macro inside `hdc_sensor_fusion`. It shares the one SRAM port between two requesters: the host loader, which writes IM folds fold-by-fold, and the encoder, which reads one fold per request during classification. It registers every SRAM control/address/data signal for gate-level timing closure, and it returns read data through a credit-checked 4-entry response FIFO. It also reports load completion and out-of-range write errors.

## Interface
- `FOLD_WIDTH`, 500: bits per IM fold (`HV_DIMENSION / NUM_FOLDS`).
- `SRAM_ADDR_WIDTH`, 10: SRAM address width.
- `NUM_ENTRIES`, 856: valid IM words (`TOTAL_NUM_CHANNEL * NUM_FOLDS`). Must be ≤ 2^`SRAM_ADDR_WIDTH`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  host write request.
- `wr_ready`  out  1  host write accepted this cycle.
- `wr_addr`  in  `SRAM_ADDR_WIDTH`  write address.
- `wr_data`  in  `FOLD_WIDTH`  write fold data.
- `rd_req_valid`  in  1  encoder read request.
- `rd_req_ready`  out  1  read request accepted this cycle.
- `rd_addr`  in  `SRAM_ADDR_WIDTH`  read address.
- `rd_resp_valid`  out  1  response FIFO head valid.
- `rd_resp_ready`  in  1  encoder consumes head.
- `rd_resp_data`  out  `FOLD_WIDTH`  response FIFO head data.
- `sram_cen`  out  1  SRAM chip enable, active-low, registered.
- `sram_wen`  out  1  SRAM write enable, active-low, registered.
- `sram_addr`  out  `SRAM_ADDR_WIDTH`  registered address.
- `sram_din`  out  `FOLD_WIDTH`  registered write data.
- `sram_dout`  in  `FOLD_WIDTH`  SRAM read data, valid one cycle after a read access cycle.
- `load_done`  out  1  sticky; set once `NUM_ENTRIES` in-range writes have been accepted.
- `wr_err`  out  1  sticky; set by any accepted write with `wr_addr` ≥ `NUM_ENTRIES`.

## Operation
- At most one grant per cycle. A handshake is `valid && ready` sampled at the rising edge.
- Credit check for reads: `credit_ok` = (FIFO occupancy + reads in flight) < 4. In flight covers up to 2 cycles. A pop in the same cycle is not credited.
- Grant rule, fixed priority (default): a write wins whenever `wr_valid` is high.
  - `wr_ready` = `wr_valid`.
  - `rd_req_ready` = `rd_req_valid && !wr_valid && credit_ok`.
- In-range accepted write: drives a write access (`cen`=0, `wen`=0, `addr`, `din`) in the next cycle and increments the load counter. The counter saturates at `NUM_ENTRIES`; `load_done` sets when it reaches that value.
- Out-of-range accepted write: handshake completes, no SRAM access is made, `wr_err` is set, the counter is unchanged.
- Accepted read: drives a read access (`cen`=0, `wen`=1) in the next cycle. `sram_dout` is pushed into the FIFO in the cycle after that. Reads are not range-checked.
- No access: `sram_cen`=1, `sram_wen`=1; `sram_addr` and `sram_din` hold their previous values.
- Response FIFO: depth 4, in order. Overflow cannot occur by construction; an overflow is a design bug and is flagged by an assertion.

## Timing
- Write accepted at edge of cycle t: SRAM write occurs in cycle t+1.
- Read accepted at edge of cycle t: SRAM read in t+1, `sram_dout` valid in t+2, `rd_resp_valid`=1 from t+3. Read latency is 3 cycles.
- Sustained throughput is 1 read per cycle when `rd_resp_ready` is held high.
- Reset values while `rst`=0: `wr_ready`=0, `rd_req_ready`=0, `rd_resp_valid`=0, `rd_resp_data`=0, `sram_cen`=1, `sram_wen`=1, `sram_addr`=0, `sram_din`=0, `load_done`=0, `wr_err`=0.
- Reset asserted mid-operation: in-flight reads are discarded, the FIFO empties, the counter and both sticky flags clear. All of this takes effect immediately (asynchronous).
- Simultaneous FIFO push and pop: occupancy is unchanged and data order is preserved.

## Configuration
- `IM_SRAM_RR_ARB_EN` defined: round-robin arbitration when both requesters are valid. A 1-bit last-grant register selects the requester not granted last, and resets to "last = write". A read that is eligible but lacks credit yields the grant to the write. Single-requester behaviour is unchanged.
- `IM_SRAM_RR_ARB_EN` undefined: fixed write priority as described in Operation. No last-grant register is instantiated.

## Test plan
- Load: write addresses 0..855 back-to-back with `wr_data` = address pattern. Required: `load_done` rises exactly 1 cycle after the 856th handshake, `sram_wen`=0 on 856 cycles, `wr_err`=0.
- Out-of-range: write to address 900. Required: `wr_ready`=1, `sram_cen` stays 1, `wr_err`=1 and stays 1.
- Streaming read: read addresses 0..199 with `rd_resp_ready`=1. Required: first `rd_resp_valid` 3 cycles after the first handshake, 200 responses on consecutive cycles, data matching the loaded pattern.
- Backpressure: `rd_resp_ready`=0 with continuous read requests. Required: exactly 4 reads accepted and then `rd_req_ready`=0. Release `rd_resp_ready`: 4 responses come out in order, then the stream resumes.
- Contention: `wr_valid` and `rd_req_valid` held high for 6 cycles.
  - Macro undefined: 6 write grants, 0 read grants.
  - `IM_SRAM_RR_ARB_EN` defined: alternating grants (R, W, R, W, R, W after reset).
- Reset mid-stream: pull `rst` low with 2 reads in flight and 1 entry in the FIFO. Required: `rd_resp_valid`=0 and `sram_cen`=1 immediately. After release, no stale response ever appears and `load_done`=0.
